// File: rtl/turn_sequencer.sv
// Turn sequencer for the two-player tank screen: alternating aim turns with a
// countdown, handshaked fire requests, per-player hit scores and win detection.
module turn_sequencer #(
  parameter int unsigned TICK_DIV     = 65_000_000,
  parameter int unsigned TURN_SECONDS = 30,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned PLAY_YMIN    = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_map,
  input  logic        button_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        fire_ack,
  input  logic        fire_done,
  input  logic        hit,
  output logic        fire_req,
  output logic [11:0] shot_x,
  output logic [11:0] shot_y,
  output logic        active_player,
  output logic [4:0]  time_left,
  output logic [3:0]  score_p0,
  output logic [3:0]  score_p1,
  output logic        game_over,
  output logic        winner
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, AIM, FIRE, FLIGHT, SWITCH, OVER} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            btn_q;
  logic            fire_req_q, fire_req_d;
  logic [11:0]     shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic            active_q, active_d;
  logic [4:0]      time_left_q, time_left_d;
  logic [3:0]      score_p0_q, score_p0_d, score_p1_q, score_p1_d;
  logic            game_over_q, game_over_d;
  logic            winner_q, winner_d;

  logic            click, valid_click, wrap;
  logic [3:0]      cur_score, inc_score;

  assign click       = button_left & ~btn_q;
  assign valid_click = click && (ypos >= 12'(PLAY_YMIN));
  assign wrap        = (presc_q == PW'(TICK_DIV - 1));
  assign cur_score   = active_q ? score_p1_q : score_p0_q;
  // Saturate so a stray extra hit can never wrap a score past the win value.
  assign inc_score   = (cur_score >= 4'(WIN_SCORE)) ? cur_score : cur_score + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      btn_q       <= 1'b0;
      fire_req_q  <= 1'b0;
      shot_x_q    <= '0;
      shot_y_q    <= '0;
      active_q    <= 1'b0;
      time_left_q <= '0;
      score_p0_q  <= '0;
      score_p1_q  <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      btn_q       <= button_left;
      fire_req_q  <= fire_req_d;
      shot_x_q    <= shot_x_d;
      shot_y_q    <= shot_y_d;
      active_q    <= active_d;
      time_left_q <= time_left_d;
      score_p0_q  <= score_p0_d;
      score_p1_q  <= score_p1_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    fire_req_d  = fire_req_q;
    shot_x_d    = shot_x_q;
    shot_y_d    = shot_y_q;
    active_d    = active_q;
    time_left_d = time_left_q;
    score_p0_d  = score_p0_q;
    score_p1_d  = score_p1_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    // Leaving the map screen abandons the game from any state.
    if (!in_map) begin
      state_d     = IDLE;
      presc_d     = '0;
      fire_req_d  = 1'b0;
      active_d    = 1'b0;
      time_left_d = '0;
      score_p0_d  = '0;
      score_p1_d  = '0;
      game_over_d = 1'b0;
      winner_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = AIM;
          presc_d     = '0;
          time_left_d = 5'(TURN_SECONDS);
          active_d    = 1'b0;
          score_p0_d  = '0;
          score_p1_d  = '0;
        end
        AIM: begin
          if (valid_click) begin
            state_d    = FIRE;
            fire_req_d = 1'b1;
            shot_x_d   = xpos;
            shot_y_d   = ypos;
          end else if (wrap) begin
            presc_d     = '0;
            time_left_d = time_left_q - 5'd1;
            if (time_left_q == 5'd1) state_d = SWITCH;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        FIRE: begin
          if (fire_ack) begin
            state_d    = FLIGHT;
            fire_req_d = 1'b0;
          end
        end
        FLIGHT: begin
          if (fire_done) begin
            state_d = SWITCH;
            if (hit) begin
              if (active_q) score_p1_d = inc_score;
              else          score_p0_d = inc_score;
              if (inc_score == 4'(WIN_SCORE)) begin
                state_d     = OVER;
                game_over_d = 1'b1;
                winner_d    = active_q;
              end
            end
          end
        end
        SWITCH: begin
          state_d     = AIM;
          active_d    = ~active_q;
          time_left_d = 5'(TURN_SECONDS);
          presc_d     = '0;
        end
        OVER: begin
          state_d = OVER;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign fire_req      = fire_req_q;
  assign shot_x        = shot_x_q;
  assign shot_y        = shot_y_q;
  assign active_player = active_q;
  assign time_left     = time_left_q;
  assign score_p0      = score_p0_q;
  assign score_p1      = score_p1_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: expectations are queued as stimulus is
// driven and compared at the falling edge after the clock edge that acts on it.
module tb_turn_sequencer;

  localparam int TICK_DIV = 4;
  localparam int TURN     = 3;
  localparam int WIN      = 2;
  localparam int YMIN     = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_map = 1'b0, button_left = 1'b0;
  logic [11:0] xpos = '0, ypos = '0;
  logic        fire_ack = 1'b0, fire_done = 1'b0, hit = 1'b0;
  logic        fire_req, active_player, game_over, winner;
  logic [11:0] shot_x, shot_y;
  logic [4:0]  time_left;
  logic [3:0]  score_p0, score_p1;

  turn_sequencer #(.TICK_DIV(TICK_DIV), .TURN_SECONDS(TURN), .WIN_SCORE(WIN), .PLAY_YMIN(YMIN)) dut (
    .clk(clk), .rst(rst), .in_map(in_map), .button_left(button_left),
    .xpos(xpos), .ypos(ypos), .fire_ack(fire_ack), .fire_done(fire_done), .hit(hit),
    .fire_req(fire_req), .shot_x(shot_x), .shot_y(shot_y), .active_player(active_player),
    .time_left(time_left), .score_p0(score_p0), .score_p1(score_p1),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef enum int {F_REQ, F_SX, F_SY, F_ACT, F_TL, F_S0, F_S1, F_GO, F_WIN} field_e;
  typedef struct {
    string  tag;
    field_e f;
    int     val;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   expAct = 0, expS0 = 0, expS1 = 0, expGo = 0, expWin = 0;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int observed(input field_e f);
    case (f)
      F_REQ:   return int'(fire_req);
      F_SX:    return int'(shot_x);
      F_SY:    return int'(shot_y);
      F_ACT:   return int'(active_player);
      F_TL:    return int'(time_left);
      F_S0:    return int'(score_p0);
      F_S1:    return int'(score_p1);
      F_GO:    return int'(game_over);
      default: return int'(winner);
    endcase
  endfunction

  task automatic expectOut(input string tag, input field_e f, input int v);
    exp_t e;
    e.tag = tag;
    e.f   = f;
    e.val = v;
    sbQ.push_back(e);
  endtask

  task automatic compareQueue();
    exp_t e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput(e.tag, observed(e.f), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compareQueue();
  endtask

  task automatic applyStimulus(input logic btn, input logic [11:0] x, input logic [11:0] y,
                               input logic ack, input logic done, input logic h);
    button_left = btn;
    xpos        = x;
    ypos        = y;
    fire_ack    = ack;
    fire_done   = done;
    hit         = h;
  endtask

  // Full turn with no click: countdown on the wrap edges, then SWITCH, then AIM.
  task automatic runTimeout();
    for (int i = 1; i <= 13; i++) begin
      if (i < 4)       expectOut("tl_cnt", F_TL, 3);
      else if (i < 8)  expectOut("tl_cnt", F_TL, 2);
      else if (i < 12) expectOut("tl_cnt", F_TL, 1);
      else if (i == 12) expectOut("tl_zero", F_TL, 0);
      else             expectOut("tl_reload", F_TL, TURN);
      expectOut(i == 13 ? "act_swap" : "act_hold", F_ACT, i == 13 ? 1 - expAct : expAct);
      tick();
    end
    expAct = 1 - expAct;
  endtask

  task automatic clickAt(input int x, input int y, input int tl);
    applyStimulus(1'b1, 12'(x), 12'(y), 1'b0, 1'b0, 1'b0);
    expectOut("req_up", F_REQ, 1);
    expectOut("shot_x", F_SX, x);
    expectOut("shot_y", F_SY, y);
    expectOut("tl_keep", F_TL, tl);
    tick();
    applyStimulus(1'b0, 12'(x), 12'(y), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic finishShot(input int ackDelay, input logic h);
    for (int i = 0; i < ackDelay; i++) begin
      expectOut("req_hold", F_REQ, 1);
      tick();
    end
    fire_ack = 1'b1;
    expectOut("req_drop", F_REQ, 0);
    tick();
    fire_ack = 1'b0;
    button_left = 1'b1;
    expectOut("flight_click", F_REQ, 0);
    tick();
    button_left = 1'b0;
    if (h) begin
      if (expAct == 0) expS0 = (expS0 < WIN) ? expS0 + 1 : expS0;
      else             expS1 = (expS1 < WIN) ? expS1 + 1 : expS1;
      if ((expAct == 0 ? expS0 : expS1) == WIN) begin
        expGo  = 1;
        expWin = expAct;
      end
    end
    fire_done = 1'b1;
    hit       = h;
    expectOut("score0", F_S0, expS0);
    expectOut("score1", F_S1, expS1);
    expectOut("over", F_GO, expGo);
    tick();
    fire_done = 1'b0;
    hit       = 1'b0;
    if (expGo == 0) begin
      expAct = 1 - expAct;
      expectOut("next_act", F_ACT, expAct);
      expectOut("next_tl", F_TL, TURN);
      tick();
    end
  endtask

  initial begin
    // Reset state, sampled while reset is still held.
    repeat (2) @(negedge clk);
    expectOut("rst_req", F_REQ, 0);
    expectOut("rst_sx", F_SX, 0);
    expectOut("rst_sy", F_SY, 0);
    expectOut("rst_act", F_ACT, 0);
    expectOut("rst_tl", F_TL, 0);
    expectOut("rst_s0", F_S0, 0);
    expectOut("rst_s1", F_S1, 0);
    expectOut("rst_go", F_GO, 0);
    expectOut("rst_win", F_WIN, 0);
    compareQueue();

    rst = 1'b1;
    expectOut("idle_tl", F_TL, 0);
    tick();
    in_map = 1'b1;
    expectOut("start_tl", F_TL, TURN);
    expectOut("start_act", F_ACT, 0);
    tick();

    runTimeout();
    runTimeout();

    clickAt(500, 300, TURN);
    finishShot(3, 1'b1);

    // HUD click is ignored; then a valid click lands on the final wrap edge.
    button_left = 1'b1;
    ypos = 12'd20;
    expectOut("hud_click", F_REQ, 0);
    tick();
    button_left = 1'b0;
    expectOut("hud_click2", F_REQ, 0);
    tick();
    for (int i = 3; i <= 11; i++) begin
      expectOut("tl_wait", F_TL, i < 4 ? 3 : (i < 8 ? 2 : 1));
      expectOut("no_req", F_REQ, 0);
      tick();
    end
    clickAt(100, 200, 1);
    expectOut("sim_act", F_ACT, expAct);
    compareQueue();
    finishShot(0, 1'b1);

    clickAt(50, 60, TURN);
    finishShot(1, 1'b0);
    clickAt(70, 80, TURN);
    finishShot(0, 1'b1);

    expectOut("go", F_GO, 1);
    expectOut("winner", F_WIN, 1);
    expectOut("final_s1", F_S1, 2);
    expectOut("frozen_tl", F_TL, TURN);
    tick();
    fire_done = 1'b1;
    hit = 1'b1;
    expectOut("over_done_s1", F_S1, 2);
    expectOut("over_hold", F_GO, 1);
    tick();
    fire_done = 1'b0;
    hit = 1'b0;

    in_map = 1'b0;
    expectOut("abort_go", F_GO, 0);
    expectOut("abort_s0", F_S0, 0);
    expectOut("abort_s1", F_S1, 0);
    expectOut("abort_tl", F_TL, 0);
    tick();
    expS0 = 0; expS1 = 0; expAct = 0; expGo = 0;

    in_map = 1'b1;
    expectOut("restart_tl", F_TL, TURN);
    tick();
    clickAt(300, 300, TURN);
    in_map = 1'b0;
    expectOut("abort_req", F_REQ, 0);
    tick();
    fire_ack = 1'b1;
    fire_done = 1'b1;
    hit = 1'b1;
    expectOut("late_done_s0", F_S0, 0);
    expectOut("late_done_s1", F_S1, 0);
    expectOut("late_req", F_REQ, 0);
    tick();
    fire_ack = 1'b0;
    fire_done = 1'b0;
    hit = 1'b0;
    expectOut("idle_s0", F_S0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Game-phase controller for the two-player tank screen. It sits downstream of the menu/map screen selector, which drives `in_map`, and sequences play on the map screen. Players alternate turns. Each turn has an aim countdown and a mouse-click fire request that is handshaked with the projectile unit. Hits are scored per player, and the block declares a winner at a fixed score.

## Interface
Parameters:
- TICK_DIV, 65_000_000: clk cycles per countdown second (65 MHz pixel clock).
- TURN_SECONDS, 30: aim time per turn, range 1..31.
- WIN_SCORE, 5: hits needed to win, range 1..15.
- PLAY_YMIN, 40: minimum ypos of a valid fire click; rows above this are HUD.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- in_map  in  1  level, high while the map screen is selected.
- button_left  in  1  left mouse button level, already synchronous to clk.
- xpos  in  12  cursor x.
- ypos  in  12  cursor y.
- fire_ack  in  1  projectile unit accepted the shot.
- fire_done  in  1  one-cycle pulse, projectile finished.
- hit  in  1  qualifies fire_done: 1 = target hit.
- fire_req  out  1  shot request, held until fire_ack.
- shot_x  out  12  xpos latched at the fire click.
- shot_y  out  12  ypos latched at the fire click.
- active_player  out  1  0 or 1.
- time_left  out  5  seconds remaining in the current aim phase.
- score_p0  out  4  hits by player 0.
- score_p1  out  4  hits by player 1.
- game_over  out  1  a player reached WIN_SCORE.
- winner  out  1  valid while game_over is high.

## Operation
- States: IDLE, AIM, FIRE, FLIGHT, SWITCH, OVER. All outputs are registered.
- Click edge: `btn_q` is button_left delayed one cycle. `click = button_left & ~btn_q`.
- IDLE:
  - Holds scores at 0, active_player at 0 and time_left at 0.
  - in_map high leads to AIM, with time_left = TURN_SECONDS and the prescaler cleared.
- AIM:
  - The prescaler counts 0..TICK_DIV-1.
  - On wrap, time_left decrements.
  - A wrap while time_left==1 sets time_left to 0 and moves to SWITCH (timeout).
  - A click with ypos >= PLAY_YMIN latches shot_x/shot_y and moves to FIRE.
  - A click with ypos < PLAY_YMIN is ignored.
  - If a valid click and a timeout wrap occur in the same cycle, the click wins and time_left is not decremented.
- FIRE:
  - fire_req is 1.
  - fire_ack leads to FLIGHT; fire_req drops on the same edge.
- FLIGHT:
  - Clicks are ignored.
  - fire_done with hit=1 increments the active player's score.
  - If the new score equals WIN_SCORE, go to OVER with winner = active_player. Otherwise go to SWITCH.
  - fire_done with hit=0 leads to SWITCH.
- SWITCH:
  - Lasts one cycle.
  - Toggles active_player, reloads time_left = TURN_SECONDS, clears the prescaler and goes to AIM.
- OVER:
  - game_over is 1. Scores, winner and time_left are frozen.
  - Exits to IDLE only when in_map goes low.
- Abort:
  - in_map low in any state leads to IDLE on the next edge. This has top priority.
  - fire_req drops on that edge. A fire_done arriving afterwards is ignored.
- Scores are clamped at WIN_SCORE and never wrap.
- fire_ack or fire_done in a state that does not expect it is ignored.

## Timing
- Reset (rst low, asynchronous):
  - State is IDLE.
  - fire_req, shot_x, shot_y, active_player, time_left, score_p0, score_p1, game_over, winner and btn_q are all 0.
- Leaving reset: the block is in IDLE on the first clk edge with rst high.
- Entering AIM: AIM with time_left = TURN_SECONDS is visible 1 cycle after the edge at which in_map is first sampled high.
- Click to request: fire_req is high 1 cycle after the edge at which the click is sampled.
- Acknowledge: fire_req is low 1 cycle after the edge at which fire_ack is sampled.
- End of shot: the fire_done edge updates the score and moves to SWITCH. The next turn's AIM follows 1 cycle later.
- Countdown: TURN_SECONDS × TICK_DIV cycles from AIM entry to timeout.
- Holding button_left does not produce repeated clicks. Only a 0→1 transition counts.

## Test plan
- Start: with TICK_DIV=4, TURN_SECONDS=3, hold rst low, then release and raise in_map.
  - Required: all outputs 0 after reset.
  - Required: time_left = 3 and active_player = 0 one cycle after in_map is sampled.
- Timeout: no clicks.
  - Required: time_left steps 3→2→1→0 every 4 cycles.
  - Required: after 12 cycles in AIM, SWITCH occurs and the next AIM shows active_player=1, time_left=3.
- Fire handshake: click at (500,300).
  - Required: fire_req=1, shot_x=500, shot_y=300.
  - Then assert fire_ack after 3 cycles. Required: fire_req=0 on the next cycle.
  - Then pulse fire_done with hit=1. Required: score_p0=1 and active_player toggles.
- HUD click, then simultaneity:
  - Click at ypos=20. Required: ignored, no fire_req.
  - Click on the cycle of the timeout wrap. Required: FIRE, with time_left unchanged.
- Win and abort:
  - With WIN_SCORE=2, deliver 2 hits by player 1. Required: game_over=1, winner=1, score_p1=2.
  - Drop in_map. Required: IDLE and scores 0.
  - Separately, drop in_map while in FIRE. Required: fire_req=0 next cycle, and a later fire_done leaves the scores unchanged.
